// File: rtl/freqmes_pkg.sv
// Shared constants for the frequency-measurement path: default counter width
// (also the SPI slave frame width), default gate length and FSM state encoding.
package freqmes_pkg;

  localparam int CNT_W_DEF       = 40;
  localparam int GATE_CYCLES_DEF = 72_000_000;
  localparam int SYNC_STAGES_DEF = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Width of a counter that must hold 0..cycles-1.
  function automatic int gate_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the asynchronous measured signal and emits a one-cycle pulse per rising edge.
// Define GLITCH_FILTER_EN to insert a 3-sample stability filter before edge detection.
module sync_edge_det
  import freqmes_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   level_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
    end
  end

`ifdef GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist <= {hist[0], sync[SYNC_STAGES-1]};
    end
  end

  // Level follows the synchronized input only after three identical consecutive samples.
  always_comb begin
    level_next = level;
    if ((sync[SYNC_STAGES-1] == hist[0]) && (hist[0] == hist[1])) begin
      level_next = sync[SYNC_STAGES-1];
    end
  end
`else
  assign level_next = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
    end else begin
      level <= level_next;
    end
  end

  assign rise = level_next & ~level;

endmodule

// File: rtl/gated_edge_counter.sv
// Counts rising edges of freq_in over GATE_CYCLES-clock windows and publishes each count,
// deferring publication while hold is high. Optional GLITCH_FILTER_EN lives in sync_edge_det.
module gated_edge_counter
  import freqmes_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk_72MHz,
  input  logic             rst,
  input  logic             freq_in,
  input  logic             hold,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             missed
);

  localparam int               GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic             win_close;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             at_max;
  logic [CNT_W-1:0] close_cnt;
  logic             close_ovf;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] pending;
  logic             pending_ovf;
  logic             pending_flag;
  logic             publish;
  logic [CNT_W-1:0] pub_cnt;
  logic             pub_ovf;
  logic             set_missed;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk_72MHz),
    .rst  (rst),
    .sig  (freq_in),
    .rise (rise)
  );

  assign win_close = (gate_cnt == GATE_LAST);
  assign at_max    = (edge_cnt == CNT_MAX);

  always_ff @(posedge clk_72MHz) begin
    if (rst || win_close) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GW'(1);
    end
  end

  // An edge seen in the closing cycle is folded into the closing value, never the next window.
  assign close_cnt = (rise && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign close_ovf = sat | (rise & at_max);

  always_ff @(posedge clk_72MHz) begin
    if (rst || win_close) begin
      edge_cnt <= '0;
      sat      <= 1'b0;
    end else if (rise) begin
      if (at_max) begin
        sat <= 1'b1;
      end else begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    pub_cnt    = close_cnt;
    pub_ovf    = close_ovf;
    set_missed = 1'b0;
    case (state)
      ST_RUN: begin
        if (win_close) begin
          if (hold) begin
            state_next = ST_HELD;
          end else begin
            publish = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (win_close) begin
          // A second close while still held drops the older pending window.
          set_missed = 1'b1;
          if (!hold) begin
            publish    = 1'b1;
            state_next = ST_RUN;
          end
        end else if (!hold) begin
          publish    = 1'b1;
          pub_cnt    = pending;
          pub_ovf    = pending_ovf;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // NOTE: the pending register is reset like the rest; it is a single word, not a memory array.
  always_ff @(posedge clk_72MHz) begin
    if (rst) begin
      state        <= ST_RUN;
      pending      <= '0;
      pending_ovf  <= 1'b0;
      pending_flag <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      missed       <= 1'b0;
    end else begin
      state        <= state_next;
      pending_flag <= (state_next == ST_HELD);
      result_valid <= publish;
      if (win_close) begin
        pending     <= close_cnt;
        pending_ovf <= close_ovf;
      end
      if (publish) begin
        result   <= pub_cnt;
        overflow <= pub_ovf;
      end
      if (set_missed) begin
        missed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gated_edge_counter.sv
// Directed bench for gated_edge_counter with GATE_CYCLES=100; a second CNT_W=3 instance
// covers saturation. Expectations follow GLITCH_FILTER_EN when it is defined.
module tb_gated_edge_counter;

  localparam int GATE = 100;
  localparam int SYNC = 2;
`ifdef GLITCH_FILTER_EN
  localparam int LAT    = SYNC + 3;
  localparam int GL_EXP = 0;
`else
  localparam int LAT    = SYNC + 1;
  localparam int GL_EXP = 10;
`endif

  logic        clk_72MHz = 1'b0;
  logic        rst;
  logic        freq_in;
  logic        freq_s;
  logic        hold;
  logic [39:0] result;
  logic        result_valid;
  logic        overflow;
  logic        missed;
  logic [2:0]  s_result;
  logic        s_valid;
  logic        s_overflow;
  logic        s_missed;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int mode        = 0;
  int mode_s      = 0;
  int rise_at     = 1000;
  int hold_on     = 0;
  int hold_off    = 0;

  always #5 clk_72MHz = ~clk_72MHz;

  gated_edge_counter #(.GATE_CYCLES(GATE), .CNT_W(40), .SYNC_STAGES(SYNC)) u_dut (
    .clk_72MHz    (clk_72MHz),
    .rst          (rst),
    .freq_in      (freq_in),
    .hold         (hold),
    .result       (result),
    .result_valid (result_valid),
    .overflow     (overflow),
    .missed       (missed)
  );

  gated_edge_counter #(.GATE_CYCLES(GATE), .CNT_W(3), .SYNC_STAGES(SYNC)) u_sat (
    .clk_72MHz    (clk_72MHz),
    .rst          (rst),
    .freq_in      (freq_s),
    .hold         (hold),
    .result       (s_result),
    .result_valid (s_valid),
    .overflow     (s_overflow),
    .missed       (s_missed)
  );

  // Stimulus waveforms indexed by cycle since reset release.
  function automatic logic wave(input int m, input int c, input int ra);
    case (m)
      1:       return ((c / 5) % 2) == 1;
      2:       return c >= ra;
      3:       return (c < 100) ? (((c / 5) % 2) == 1) : (((c / 10) % 2) == 1);
      4:       return (c < 100) ? (((c / 5) % 2) == 1)
                                : ((c >= 110 && c <= 114) || (c >= 130 && c <= 134));
      5:       return ((c % 10) == 3) || ((c % 10) == 4);
      6:       return (c >= 100) && (((c / 5) % 2) == 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive();
    freq_in = wave(mode, cyc, rise_at);
    freq_s  = wave(mode_s, cyc, rise_at);
    hold    = (cyc >= hold_on) && (cyc < hold_off);
  endtask

  task automatic step();
    @(negedge clk_72MHz);
    cyc++;
    drive();
  endtask

  // One-cycle reset applied at the current negedge; returns mid-cycle 0 of a fresh window.
  task automatic do_reset();
    rst      = 1'b1;
    mode     = 0;
    mode_s   = 0;
    hold_on  = 0;
    hold_off = 0;
    freq_in  = 1'b0;
    freq_s   = 1'b0;
    hold     = 1'b0;
    @(negedge clk_72MHz);
    rst = 1'b0;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset(input string tag);
    vectors++;
    if (result !== 40'd0) begin
      miscompares++; $display("FAIL %s_result: got %0d expected 0", tag, result);
    end
    vectors++;
    if (result_valid !== 1'b0) begin
      miscompares++; $display("FAIL %s_valid: got %b expected 0", tag, result_valid);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++; $display("FAIL %s_overflow: got %b expected 0", tag, overflow);
    end
    vectors++;
    if (missed !== 1'b0) begin
      miscompares++; $display("FAIL %s_missed: got %b expected 0", tag, missed);
    end
    vectors++;
    if (s_result !== 3'd0 || s_valid !== 1'b0 || s_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_sat: got result %0d valid %b ovf %b expected all 0",
               tag, s_result, s_valid, s_overflow);
    end
  endtask

  task automatic test_rate();
    logic exp_v;
    do_reset();
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_v = (cyc % 100) == 0;
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL rate_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (result !== 40'd10 || overflow !== 1'b0 || missed !== 1'b0) begin
          miscompares++;
          $display("FAIL rate_result c=%0d: got %0d ovf %b missed %b expected 10 0 0",
                   cyc, result, overflow, missed);
        end
      end
    end
  endtask

  task automatic test_closing_edge();
    logic exp_v;
    int   exp_r;
    do_reset();
    rise_at = 200 - LAT;
    mode    = 2;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_v = (cyc % 100) == 0;
      exp_r = (cyc == 200) ? 1 : 0;
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL close_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (result !== 40'(exp_r)) begin
          miscompares++; $display("FAIL close_result c=%0d: got %0d expected %0d", cyc, result, exp_r);
        end
      end
    end
    rise_at = 1000;
  endtask

  task automatic test_hold_once();
    logic exp_v;
    int   exp_r;
    do_reset();
    mode     = 6;
    hold_on  = 150;
    hold_off = 230;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_v = (cyc == 100) || (cyc == 231) || (cyc == 300);
      exp_r = (cyc < 231) ? 0 : 10;
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL hold1_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
      vectors++;
      if (result !== 40'(exp_r)) begin
        miscompares++; $display("FAIL hold1_result c=%0d: got %0d expected %0d", cyc, result, exp_r);
      end
    end
    vectors++;
    if (missed !== 1'b0) begin
      miscompares++; $display("FAIL hold1_missed: got %b expected 0", missed);
    end
  endtask

  task automatic test_hold_twice();
    logic exp_v;
    logic exp_m;
    int   exp_r;
    do_reset();
    mode     = 3;
    hold_on  = 50;
    hold_off = 250;
    for (int i = 0; i < 300; i++) begin
      step();
      exp_v = (cyc == 251) || (cyc == 300);
      exp_r = (cyc < 251) ? 0 : 5;
      exp_m = (cyc >= 200);
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL hold2_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
      vectors++;
      if (result !== 40'(exp_r)) begin
        miscompares++; $display("FAIL hold2_result c=%0d: got %0d expected %0d", cyc, result, exp_r);
      end
      vectors++;
      if (missed !== exp_m) begin
        miscompares++; $display("FAIL hold2_missed c=%0d: got %b expected %b", cyc, missed, exp_m);
      end
    end
    do_reset();
    test_reset("hold2_clear");
  endtask

  task automatic test_close_release();
    logic exp_v;
    do_reset();
    mode     = 3;
    hold_on  = 50;
    hold_off = 199;
    for (int i = 0; i < 200; i++) begin
      step();
      exp_v = (cyc == 200);
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL relclose_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
    end
    vectors++;
    if (result !== 40'd5 || missed !== 1'b1) begin
      miscompares++;
      $display("FAIL relclose_result: got %0d missed %b expected 5 missed 1", result, missed);
    end
  endtask

  task automatic test_saturation();
    logic exp_v;
    do_reset();
    mode_s = 4;
    for (int i = 0; i < 200; i++) begin
      step();
      exp_v = (cyc % 100) == 0;
      vectors++;
      if (s_valid !== exp_v) begin
        miscompares++; $display("FAIL sat_valid c=%0d: got %b expected %b", cyc, s_valid, exp_v);
      end
      if (cyc == 100) begin
        vectors++;
        if (s_result !== 3'd7 || s_overflow !== 1'b1) begin
          miscompares++; $display("FAIL sat_full: got %0d ovf %b expected 7 ovf 1", s_result, s_overflow);
        end
      end
      if (cyc == 200) begin
        vectors++;
        if (s_result !== 3'd2 || s_overflow !== 1'b0) begin
          miscompares++; $display("FAIL sat_next: got %0d ovf %b expected 2 ovf 0", s_result, s_overflow);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic exp_v;
    do_reset();
    mode = 1;
    for (int i = 0; i < 160; i++) begin
      step();
      if (cyc == 100) begin
        vectors++;
        if (result !== 40'd10) begin
          miscompares++; $display("FAIL midrst_pre: got %0d expected 10", result);
        end
      end
    end
    do_reset();
    test_reset("midrst");
    mode = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      exp_v = (cyc == 100);
      vectors++;
      if (result_valid !== exp_v) begin
        miscompares++; $display("FAIL midrst_valid c=%0d: got %b expected %b", cyc, result_valid, exp_v);
      end
    end
    vectors++;
    if (result !== 40'd10) begin
      miscompares++; $display("FAIL midrst_result: got %0d expected 10", result);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    mode = 5;
    for (int i = 0; i < 100; i++) step();
    vectors++;
    if (result_valid !== 1'b1 || result !== 40'(GL_EXP)) begin
      miscompares++;
      $display("FAIL glitch: got %0d valid %b expected %0d valid 1", result, result_valid, GL_EXP);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    test_reset("reset");
    test_rate();
    test_closing_edge();
    test_hold_once();
    test_hold_twice();
    test_close_release();
    test_saturation();
    test_mid_reset();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
